md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the EX stage, alongside the integer ALU.
- Consumes the same forwarded operand pair A/B as the ALU.
- Owns the architectural HI/LO registers and serves MFHI/MFLO reads.
- Multi-cycle: reports busy so the hazard unit stalls the ID stage while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family when enabled); legal range 1..31
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..31

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- MDOp  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, others NOP
- start  input  1  qualifies MDOp for one cycle; EX stage asserts it only for a valid, non-flushed instruction
- busy  output  1  registered; high while an operation is in flight
- stall_req  output  1  combinational; busy OR (start AND MDOp is a multi-cycle op)
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (synchronous, high at a clk edge):
  - HI=0, LO=0, busy=0, counter=0.
  - Any in-flight operation is discarded with no HI/LO update.
  - Reset dominates start in the same cycle.
- Accept: op accepted at edge t iff start=1, busy=0, reset=0.
  - A, B and the op are captured into internal registers at edge t.
  - A/B changes after t have no effect.
- Multi-cycle ops (MULT, MULTU, DIV, DIVU, MADD-family):
  - busy=1 from edge t through edge t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - Counter loaded with N at edge t, decremented each edge.
  - At edge t+N: HI/LO updated and busy cleared together.
  - New HI/LO visible in the first cycle with busy=0.
  - busy is high for exactly N cycles.
- MTHI/MTLO:
  - Single cycle: HI<=A or LO<=A at edge t.
  - busy never asserted.
- start while busy=1: ignored entirely. Legal stream never does this because stall_req holds ID.
- NOP or undefined MDOp with start=1: no effect.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit A*B.
  - MULTU: unsigned 64-bit A*B.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
  - Divide by zero (DIV or DIVU): op still runs DIV_CYCLES with busy high; HI and LO left unchanged at completion.
- Results are computed on the captured operands. Computing in one step and delaying publication by the counter is legal; only the port-visible timing is specified.
- HI/LO outputs are direct register outputs; no bypass of an in-flight result.

Optional Feature:
- Macro: MD_MADD_EN
- Defined:
  - MDOp 7..10 accepted as multi-cycle ops with MULT_CYCLES latency.
  - MADD: {HI,LO} += signed A*B; MADDU: unsigned version.
  - MSUB: {HI,LO} -= signed A*B; MSUBU: unsigned version.
  - All are 64-bit modulo arithmetic.
  - Accumulation uses the {HI,LO} value at edge t.
- Undefined: MDOp 7..10 treated as NOP; busy stays 0 and HI/LO unchanged.

Test Plan:
- MULT A=0xFFFFFFFF B=0x00000002 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7 B=2 -> LO=3, HI=1.
- MTHI A=0x12345678 -> HI=0x12345678 next cycle, busy never 1. DIVU A=7 B=0 afterwards -> busy 10 cycles, then HI=0x12345678, LO unchanged.
- MULT started; A/B changed and start+DIV pulsed during busy -> DIV ignored, result from the captured MULT operands, busy 5 cycles only. stall_req=1 in the start cycle with busy=0.
- DIV started, reset asserted at cycle 4 -> HI=LO=0, busy=0 next edge, no later update. start+MULT together with reset -> not accepted.
- MD_MADD_EN defined: HI=0, LO=0xFFFFFFFF, MADDU A=1 B=1 -> HI=1, LO=0. MSUB A=1 B=1 from HI=LO=0 -> HI=LO=0xFFFFFFFF. Undefined build: MDOp 7 -> no busy, HI/LO unchanged.

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - EX-stage multiply/divide unit owning HI/LO; define MD_MADD_EN for MADD/MADDU/MSUB/MSUBU
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;
    logic        b_nz, is_multi;
`ifdef MD_MADD_EN
    logic [63:0] acc;
`endif

    // The full result is computed at accept; the counter only delays publication.
    always_comb begin
        prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u  = {32'd0, A} * {32'd0, B};
        b_nz    = (B != 32'd0);
        abs_a   = A[31] ? (32'd0 - A) : A;
        abs_b   = B[31] ? (32'd0 - B) : B;
        quo_mag = b_nz ? (abs_a / abs_b) : 32'd0;
        rem_mag = b_nz ? (abs_a % abs_b) : 32'd0;
        quo_s   = (A[31] ^ B[31]) ? (32'd0 - quo_mag) : quo_mag;
        rem_s   = A[31] ? (32'd0 - rem_mag) : rem_mag;
        quo_u   = b_nz ? (A / B) : 32'd0;
        rem_u   = b_nz ? (A % B) : 32'd0;
`ifdef MD_MADD_EN
        acc     = {hi_q, lo_q};
`endif
    end

    always_comb begin
        is_multi = 1'b0;
        case (MDOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_multi = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_multi = 1'b1;
`endif
            default: is_multi = 1'b0;
        endcase
    end

    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        if (busy_q) begin
            if (cnt_q <= 5'd1) begin
                busy_d = 1'b0;
                cnt_d  = 5'd0;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end else begin
                cnt_d = cnt_q - 5'd1;
            end
        end else if (start) begin
            case (MDOp)
                OP_MULT: begin
                    busy_d = 1'b1; cnt_d = MULT_N; pend_wr_d = 1'b1;
                    {pend_hi_d, pend_lo_d} = prod_s;
                end
                OP_MULTU: begin
                    busy_d = 1'b1; cnt_d = MULT_N; pend_wr_d = 1'b1;
                    {pend_hi_d, pend_lo_d} = prod_u;
                end
                // Divide by zero still occupies the unit but leaves HI/LO untouched.
                OP_DIV: begin
                    busy_d = 1'b1; cnt_d = DIV_N; pend_wr_d = b_nz;
                    pend_hi_d = rem_s; pend_lo_d = quo_s;
                end
                OP_DIVU: begin
                    busy_d = 1'b1; cnt_d = DIV_N; pend_wr_d = b_nz;
                    pend_hi_d = rem_u; pend_lo_d = quo_u;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
`ifdef MD_MADD_EN
                OP_MADD: begin
                    busy_d = 1'b1; cnt_d = MULT_N; pend_wr_d = 1'b1;
                    {pend_hi_d, pend_lo_d} = acc + prod_s;
                end
                OP_MADDU: begin
                    busy_d = 1'b1; cnt_d = MULT_N; pend_wr_d = 1'b1;
                    {pend_hi_d, pend_lo_d} = acc + prod_u;
                end
                OP_MSUB: begin
                    busy_d = 1'b1; cnt_d = MULT_N; pend_wr_d = 1'b1;
                    {pend_hi_d, pend_lo_d} = acc - prod_s;
                end
                OP_MSUBU: begin
                    busy_d = 1'b1; cnt_d = MULT_N; pend_wr_d = 1'b1;
                    {pend_hi_d, pend_lo_d} = acc - prod_u;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= 1'b0;
            cnt_q     <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy      = busy_q;
    assign stall_req = busy_q | (start & is_multi);
    assign HI        = hi_q;
    assign LO        = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit; build with MD_MADD_EN to cover the accumulate ops
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDOp;
    logic        start;
    logic        busy, stall_req;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .start(start),
        .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Issues one op and counts busy cycles; returns with HI/LO sampled in the first non-busy cycle.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int bcyc, output logic stall_obs);
        @(negedge clk);
        MDOp = op; A = a; B = b; start = 1'b1;
        #1 stall_obs = stall_req;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; MDOp = 4'd0; A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D;
        bcyc = 0;
        while (busy === 1'b1 && bcyc < 64) begin
            bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int q, r;
        case (op)
            4'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
            4'd2: return {32'd0, a} * {32'd0, b};
            4'd3: begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); return {r, q}; end
            default: return {a % b, a / b};
        endcase
    endfunction

    task automatic check_pop(input int bcyc);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty actual=0 required>0");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (HI !== e.hi) begin failures++; $display("FAIL %s_hi actual=%h required=%h", e.name, HI, e.hi); end
        checks++;
        if (LO !== e.lo) begin failures++; $display("FAIL %s_lo actual=%h required=%h", e.name, LO, e.lo); end
        checks++;
        if (bcyc !== e.cyc) begin failures++; $display("FAIL %s_busy actual=%0d required=%0d", e.name, bcyc, e.cyc); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy !== 1'b0 || stall_req !== 1'b0) begin
            failures++; $display("FAIL reset_busy actual=%b/%b required=0/0", busy, stall_req);
        end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            failures++; $display("FAIL reset_hilo actual=%h_%h required=0_0", HI, LO);
        end
    endtask

    task automatic test_mult();
        int c; logic s;
        sb.push_back('{"mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5});
        do_op(4'd1, 32'hFFFF_FFFF, 32'h2, c, s);
        check_pop(c);
        checks++;
        if (s !== 1'b1) begin failures++; $display("FAIL mult_stall actual=%b required=1", s); end
        sb.push_back('{"multu", 32'h1, 32'hFFFF_FFFE, 5});
        do_op(4'd2, 32'hFFFF_FFFF, 32'h2, c, s);
        check_pop(c);
    endtask

    task automatic test_div();
        int c; logic s;
        sb.push_back('{"div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        do_op(4'd3, 32'hFFFF_FFF9, 32'h2, c, s);
        check_pop(c);
        sb.push_back('{"div_ovf", 32'h0, 32'h8000_0000, 10});
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, c, s);
        check_pop(c);
        sb.push_back('{"divu", 32'h1, 32'h3, 10});
        do_op(4'd4, 32'h7, 32'h2, c, s);
        check_pop(c);
    endtask

    task automatic test_mthi_divzero();
        int c; logic s;
        sb.push_back('{"mthi", 32'h1234_5678, 32'h3, 0});
        do_op(4'd5, 32'h1234_5678, 32'h0, c, s);
        check_pop(c);
        checks++;
        if (s !== 1'b0) begin failures++; $display("FAIL mthi_stall actual=%b required=0", s); end
        sb.push_back('{"mtlo", 32'h1234_5678, 32'hA5A5_0001, 0});
        do_op(4'd6, 32'hA5A5_0001, 32'h0, c, s);
        check_pop(c);
        sb.push_back('{"divu_zero", 32'h1234_5678, 32'hA5A5_0001, 10});
        do_op(4'd4, 32'h7, 32'h0, c, s);
        check_pop(c);
        sb.push_back('{"nop15", 32'h1234_5678, 32'hA5A5_0001, 0});
        do_op(4'd15, 32'h1, 32'h1, c, s);
        check_pop(c);
    endtask

    task automatic test_capture_ignore();
        int c; logic s;
        sb.push_back('{"capture", 32'h0, 32'd15, 5});
        @(negedge clk);
        MDOp = 4'd1; A = 32'd3; B = 32'd5; start = 1'b1;
        #1 s = stall_req;
        checks++;
        if (s !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL capture_stall actual=%b/%b required=1/0", s, busy);
        end
        @(posedge clk);
        @(negedge clk);
        MDOp = 4'd3; A = 32'd100; B = 32'd7; start = 1'b1;
        c = 0;
        while (busy === 1'b1 && c < 64) begin
            c++;
            @(negedge clk);
            start = 1'b0; A = 32'd9; B = 32'd9; MDOp = 4'd0;
        end
        check_pop(c);
        repeat (12) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd15) begin
            failures++; $display("FAIL capture_no_div actual=%b_%h_%h required=0_0_f", busy, HI, LO);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        MDOp = 4'd3; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; MDOp = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++; $display("FAIL midop_reset actual=%b_%h_%h required=0_0_0", busy, HI, LO);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            failures++; $display("FAIL midop_late actual=%h_%h required=0_0", HI, LO);
        end
        reset = 1'b1; start = 1'b1; MDOp = 4'd1; A = 32'd3; B = 32'd3;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b0; MDOp = 4'd0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_vs_start actual=%b required=0", busy); end
        repeat (7) @(negedge clk);
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            failures++; $display("FAIL reset_vs_start_hilo actual=%h_%h required=0_0", HI, LO);
        end
    endtask

    task automatic test_random();
        int c; logic s;
        logic [31:0] a, b;
        logic [3:0] op;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            op = 4'(1 + (i % 4));
            a = $urandom;
            b = $urandom;
            if (op >= 4'd3) begin
                if (i[2]) b = b >> $urandom_range(31, 20);
                if (b == 32'd0) b = 32'd13;
                if (a == 32'h8000_0000) a = 32'h8000_0001;
            end
            r = model(op, a, b);
            sb.push_back('{$sformatf("rand%0d", i), r[63:32], r[31:0], (op >= 4'd3) ? 10 : 5});
            do_op(op, a, b, c, s);
            check_pop(c);
        end
    endtask

    task automatic test_madd();
        int c; logic s;
`ifdef MD_MADD_EN
        do_op(4'd5, 32'h0, 32'h0, c, s);
        do_op(4'd6, 32'hFFFF_FFFF, 32'h0, c, s);
        sb.push_back('{"maddu", 32'h1, 32'h0, 5});
        do_op(4'd8, 32'h1, 32'h1, c, s);
        check_pop(c);
        do_op(4'd5, 32'h0, 32'h0, c, s);
        do_op(4'd6, 32'h0, 32'h0, c, s);
        sb.push_back('{"msub", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5});
        do_op(4'd9, 32'h1, 32'h1, c, s);
        check_pop(c);
        checks++;
        if (s !== 1'b1) begin failures++; $display("FAIL msub_stall actual=%b required=1", s); end
`else
        do_op(4'd5, 32'h0BAD_0001, 32'h0, c, s);
        do_op(4'd6, 32'h0BAD_0002, 32'h0, c, s);
        sb.push_back('{"madd_off", 32'h0BAD_0001, 32'h0BAD_0002, 0});
        do_op(4'd7, 32'h5, 32'h5, c, s);
        check_pop(c);
        checks++;
        if (s !== 1'b0) begin failures++; $display("FAIL madd_off_stall actual=%b required=0", s); end
`endif
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; MDOp = 4'd0; A = 32'd0; B = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_divzero();
        test_capture_ignore();
        test_reset_midop();
        test_random();
        test_madd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
